// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: word width, ALU operation codes and the
// state encoding of the shift-add multiplier sequencer.
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [3:0] {
      ALU_SLL  = 4'd0,
      ALU_SRL  = 4'd1,
      ALU_ADD  = 4'd2,
      ALU_SUB  = 4'd3,
      ALU_AND  = 4'd4,
      ALU_OR   = 4'd5,
      ALU_XOR  = 4'd6,
      ALU_NOR  = 4'd7,
      ALU_SLT  = 4'd8,
      ALU_SLTU = 4'd9
   } aluop_t;

   // Shift distance used to double the multiplicand each SHIFT step.
   localparam word_t SHAMT_ONE = 32'd1;

   typedef enum logic [1:0] {
      MS_IDLE,
      MS_ADD,
      MS_SHIFT,
      MS_DONE
   } mult_state_t;

endpackage

// File: rtl/alu_mult_seq.sv
// Multi-cycle shift-add multiplier. Borrows the shared ALU (ADD / SLL) to
// build the low 32 bits of op_a*op_b, skipping zero multiplier bits and
// stopping as soon as the remaining multiplier is zero.
module alu_mult_seq
   import cpu_types_pkg::*;
(
   input  logic   CLK,
   input  logic   nRST,
   input  logic   start,
   input  logic   flush,
   input  word_t  op_a,
   input  word_t  op_b,
   output logic   busy,
   output logic   done,
   output word_t  product,
   output logic   alu_own,
   output aluop_t alu_op,
   output word_t  alu_porta,
   output word_t  alu_portb,
   input  word_t  alu_out
);

   mult_state_t r_state;
   mult_state_t w_next_state;
   word_t       r_acc;
   word_t       r_mcand;
   word_t       r_mplier;
   word_t       w_mplier_shr;

   // The multiplier is shifted locally; the ALU is only used for the datapath words.
   assign w_mplier_shr = r_mplier >> 1;

   // The accumulator is the product; it is only meaningful once done pulses.
   assign product = r_acc;

   // Next-state selection and ALU drive for the current step.
   always_comb begin
      // NOTE: every output of this block gets a default first so no path can infer a latch.
      w_next_state = r_state;
      busy         = 1'b0;
      done         = 1'b0;
      alu_own      = 1'b0;
      alu_op       = ALU_ADD;
      alu_porta    = '0;
      alu_portb    = '0;
      case (r_state)
         MS_IDLE: begin
            if (start) begin
               if (op_b == '0)   w_next_state = MS_DONE;
               else if (op_b[0]) w_next_state = MS_ADD;
               else              w_next_state = MS_SHIFT;
            end
         end
         MS_ADD: begin
            busy         = 1'b1;
            alu_own      = 1'b1;
            alu_op       = ALU_ADD;
            alu_porta    = r_acc;
            alu_portb    = r_mcand;
            w_next_state = MS_SHIFT;
         end
         MS_SHIFT: begin
            busy      = 1'b1;
            alu_own   = 1'b1;
            alu_op    = ALU_SLL;
            alu_porta = r_mcand;
            alu_portb = SHAMT_ONE;
            if (w_mplier_shr == '0)   w_next_state = MS_DONE;
            else if (w_mplier_shr[0]) w_next_state = MS_ADD;
            else                      w_next_state = MS_SHIFT;
         end
         MS_DONE: begin
            done         = 1'b1;
            w_next_state = MS_IDLE;
         end
         default: w_next_state = MS_IDLE;
      endcase
      // Abort overrides every transition, including a start seen in IDLE.
      if (flush) w_next_state = MS_IDLE;
   end

   // State and operand registers; flush freezes the operands while returning to IDLE.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_state  <= MS_IDLE;
         r_acc    <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the pre-edge values.
         r_state <= w_next_state;
         if (!flush) begin
            case (r_state)
               MS_IDLE: begin
                  if (start) begin
                     r_acc    <= '0;
                     r_mcand  <= op_a;
                     r_mplier <= op_b;
                  end
               end
               MS_ADD:   r_acc <= alu_out;
               MS_SHIFT: begin
                  r_mcand  <= alu_out;
                  r_mplier <= w_mplier_shr;
               end
               default: ;
            endcase
         end
      end
   end

endmodule
